// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared constants for the core-facing I/O bridge: byte width, default FIFO
// depths and the bit layout of the io_status word.
//   io_status = {rx_overflow, 7'b0, rx_count[7:0], tx_count[7:0], 8'b0}
// ----------------------------------------------------------------------------
package io_pkg;

  localparam int unsigned IO_BYTE_W         = 8;
  localparam int unsigned IO_WORD_W         = 32;

  localparam int unsigned TX_DEPTH_LOG2_DEF = 4;
  localparam int unsigned RX_DEPTH_LOG2_DEF = 4;

  // io_status field offsets
  localparam int unsigned STAT_OVF_BIT      = 31;
  localparam int unsigned STAT_RX_CNT_LSB   = 16;
  localparam int unsigned STAT_TX_CNT_LSB   = 8;

  // FIFO occupancy is DEPTH_LOG2+1 bits wide; the status word always shows the
  // low byte, zero-extended for small FIFOs and truncated for large ones.
  function automatic logic [IO_BYTE_W-1:0] count_to_byte(input logic [31:0] cnt);
    return cnt[IO_BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/io_bridge_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with register storage and a head-of-queue output that is
// valid with no read bubble.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din at the edge when not full (full blocks the write even
//              if a pop happens in the same cycle)
//   pop      : advance the head at the edge when not empty
//   dout     : current head entry
//   full/empty/count : occupancy, derived from wrap-bit pointers
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  PTR_ONE = 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  // Pointers carry one extra wrap bit: equal means empty, equal apart from the
  // wrap bit means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is read straight out of the storage registers, so it is available in
  // the cycle after the write with no extra stage.
  assign dout = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // Storage is cleared too so the head output is a defined zero after reset.
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// ----------------------------------------------------------------------------
// io_bridge
// Core-facing I/O responder. Core byte writes go into a TX FIFO that drains to
// a byte-stream transmitter; bytes from a receiver fill an RX FIFO that serves
// core reads. The core is stalled when a FIFO cannot take or supply a byte.
//   clk, rst               : clock, synchronous active-high reset
//   out_issued/out_data    : core write request, byte in out_data[7:0]
//   out_stall              : TX full, core must retry
//   in_issued              : core read request
//   in_stall               : RX empty, core must retry
//   in_data                : {24'b0, byte}; holds last served byte otherwise
//   tx_data/tx_valid/ready : transmitter handshake
//   rx_data/rx_valid       : receiver strobe
//   io_status              : {rx_overflow, 7'b0, rx_count, tx_count, 8'b0}
// ----------------------------------------------------------------------------
module io_bridge
  import io_pkg::*;
#(
  parameter int unsigned TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEF,
  parameter int unsigned RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  out_issued,
  input  logic [IO_WORD_W-1:0]  out_data,
  output logic                  out_stall,
  input  logic                  in_issued,
  output logic                  in_stall,
  output logic [IO_WORD_W-1:0]  in_data,
  output logic [IO_BYTE_W-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [IO_BYTE_W-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic [IO_WORD_W-1:0]  io_status
);

  logic                    tx_full, tx_empty, tx_push, tx_pop;
  logic [TX_DEPTH_LOG2:0]  tx_count;

  logic                    rx_full, rx_empty, rx_push, rx_pop;
  logic [RX_DEPTH_LOG2:0]  rx_count;
  logic [IO_BYTE_W-1:0]    rx_head;

  logic                    rx_overflow_q, rx_overflow_d;
  logic [IO_BYTE_W-1:0]    in_byte_q, in_byte_d;

  logic                    out_data_unused;
  assign out_data_unused = ^out_data[IO_WORD_W-1:IO_BYTE_W];

  // ---------------- TX path ----------------
  assign out_stall = out_issued & tx_full;
  assign tx_push   = out_issued & ~tx_full;
  assign tx_valid  = ~tx_empty;
  assign tx_pop    = tx_valid & tx_ready;

  sync_fifo #(
    .WIDTH      (IO_BYTE_W),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (out_data[IO_BYTE_W-1:0]),
    .pop   (tx_pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // ---------------- RX path ----------------
  assign rx_push  = rx_valid & ~rx_full;
  assign in_stall = in_issued & rx_empty;
  assign rx_pop   = in_issued & ~rx_empty;

  sync_fifo #(
    .WIDTH      (IO_BYTE_W),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // in_data shows the head while a read is being served and otherwise keeps
  // the last byte handed to the core.
  assign in_data = {{(IO_WORD_W-IO_BYTE_W){1'b0}}, (rx_pop ? rx_head : in_byte_q)};

  always_comb begin
    rx_overflow_d = rx_overflow_q | (rx_valid & rx_full);
    in_byte_d     = rx_pop ? rx_head : in_byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow_q <= 1'b0;
      in_byte_q     <= '0;
    end else begin
      rx_overflow_q <= rx_overflow_d;
      in_byte_q     <= in_byte_d;
    end
  end

  // ---------------- status ----------------
  always_comb begin
    io_status                                  = '0;
    io_status[STAT_OVF_BIT]                    = rx_overflow_q;
    io_status[STAT_RX_CNT_LSB +: IO_BYTE_W]    = count_to_byte(32'(rx_count));
    io_status[STAT_TX_CNT_LSB +: IO_BYTE_W]    = count_to_byte(32'(tx_count));
  end

endmodule
